keccak_absorb_packer: RTL and testbench
=======================================

// Module: keccak_absorb_packer
// PURPOSE
//  Parametrised successor to the 16-bit pad/register path. AXI-Stream slave taking DATA_WIDTH-bit beats;
//  packs bytes into rate-sized blocks, applies Keccak pad10*1 with domain byte per mode (SHA3/SHAKE),
//  emits 1600-bit blocks to the permutation core over a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH  16  stream width in bits; legal 8/16/32/64 (all rates are multiples of 8 bytes)
//  ID_WIDTH    8   TID width; latched per message, forwarded on blk_id
// PORTS
//  ACLK       in   1           clock; all logic on rising edge
//  ARESETn    in   1           synchronous reset, active low
//  TVALID     in   1           slave beat valid
//  TREADY     out  1           slave ready
//  TDATA      in   DATA_WIDTH  beat data; byte k = TDATA[8k+7:8k], byte 0 first in message
//  TKEEP      in   DATA_WIDTH/8  byte enables; must be all-ones except on TLAST beat
//  TLAST      in   1           last beat of message
//  TUSER      in   3           mode: 0 SHA3-224 r=144B, 1 SHA3-256 r=136B, 2 SHA3-384 r=104B,
//                              3 SHA3-512 r=72B, 4 SHAKE128 r=168B, 5 SHAKE256 r=136B
//  TID        in   ID_WIDTH    message id
//  blk_valid  out  1           block valid
//  blk_ready  in   1           core accepts block
//  blk_data   out  1600        block; byte i = blk_data[8i+7:8i]; bytes >= rate always 0
//  blk_last   out  1           block is final (padded) block of message
//  blk_mode   out  3           latched mode of message
//  blk_id     out  ID_WIDTH    latched TID of message
//  mode_err   out  1           one-cycle pulse: TUSER 6/7 at message start
// BEHAVIOUR
//  Reset (ARESETn=0 at edge): TREADY=0, blk_valid=0, blk_data=0, blk_last=0, blk_mode=0, blk_id=0,
//   mode_err=0, byte_ptr=0, pad_pending=0, state=FILL. Reset mid-message discards all; no block emitted.
//  TREADY=1 in FILL from the cycle after reset release; beat accepted on TVALID&TREADY.
//  Mode/TID latched on first beat of a message (byte_ptr==0 & !in_msg); later TUSER/TID changes ignored.
//  TUSER 6/7: mode_err pulse, message processed as mode 1.
//  TKEEP: bytes with TKEEP=1 written at byte_ptr.., ptr += popcount; non-contiguous TKEEP undefined.
//  FSM states FILL, EMIT:
//   FILL, beat !TLAST, ptr+n==rate -> EMIT, blk_last=0.
//   FILL, beat TLAST, ptr+n<rate -> byte[ptr+n]^=D, byte[rate-1]^=0x80, EMIT, blk_last=1.
//     D=0x06 (SHA3) / 0x1F (SHAKE); if ptr+n==rate-1 that byte = D|0x80.
//   FILL, beat TLAST, ptr+n==rate -> EMIT blk_last=0, pad_pending=1.
//   TLAST with TKEEP=0 legal: zero bytes added (empty message -> single pad block).
//   EMIT: blk_valid=1, TREADY=0, blk_* stable until blk_ready.
//    blk_ready & pad_pending -> buffer = zero, byte0=D, byte[rate-1]^=0x80, blk_last=1, pad_pending=0, stay EMIT.
//    blk_ready & !pad_pending -> buffer zeroed, ptr=0, FILL (TREADY=1 next cycle).
//  Latency: blk_valid asserts the cycle after the completing beat is accepted.
//  Throughput: one beat/cycle in FILL; one idle input cycle per emitted block minimum.
// TESTING
//  Empty SHA3-256: one beat TKEEP=0 TLAST TUSER=1 -> 1 block, byte0=0x06, byte135=0x80, rest 0, blk_last=1.
//  "abc" SHAKE128, W=16: {6261,keep11},{0063,keep01,last} -> bytes 61 62 63 1F, byte167=0x80, blk_last=1.
//  SHA3-256 136-byte msg, W=16 (68 beats) -> block1 full data blk_last=0; block2 byte0=06, byte135=80, blk_last=1.
//  SHA3-256 135-byte msg -> single block, byte135=0x86, blk_last=1.
//  blk_ready low 5 cycles in EMIT -> blk_data/blk_last stable, TREADY=0; TUSER change mid-message -> blk_mode unchanged.
//  ARESETn low mid-message then 3-byte msg -> no stale block; output block holds only new bytes; TUSER=7 -> mode_err pulse, blk_mode=1.

Source files
------------

// File: rtl/keccak_absorb_packer.sv
// Keccak absorb front end: packs AXI-Stream bytes into rate-sized blocks,
// applies pad10*1 with the SHA3/SHAKE domain byte and hands 1600-bit blocks on.
module keccak_absorb_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    TVALID,
    output logic                    TREADY,
    input  logic [DATA_WIDTH-1:0]   TDATA,
    input  logic [DATA_WIDTH/8-1:0] TKEEP,
    input  logic                    TLAST,
    input  logic [2:0]              TUSER,
    input  logic [ID_WIDTH-1:0]     TID,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [1599:0]           blk_data,
    output logic                    blk_last,
    output logic [2:0]              blk_mode,
    output logic [ID_WIDTH-1:0]     blk_id,
    output logic                    mode_err
);

    localparam int NB = DATA_WIDTH / 8;

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    function automatic logic [7:0] rate_of(input logic [2:0] m);
        logic [7:0] r;
        case (m)
            3'd0:    r = 8'd144;
            3'd1:    r = 8'd136;
            3'd2:    r = 8'd104;
            3'd3:    r = 8'd72;
            3'd4:    r = 8'd168;
            default: r = 8'd136;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] dom_of(input logic [2:0] m);
        return (m == 3'd4 || m == 3'd5) ? 8'h1F : 8'h06;
    endfunction

    function automatic logic [1599:0] set_byte(
        input logic [1599:0] b,
        input logic [7:0]    pos,
        input logic [7:0]    v
    );
        logic [1599:0] r;
        r = b;
        r[{pos, 3'b000} +: 8] = v;
        return r;
    endfunction

    function automatic logic [1599:0] xor_byte(
        input logic [1599:0] b,
        input logic [7:0]    pos,
        input logic [7:0]    v
    );
        logic [1599:0] r;
        r = b;
        r[{pos, 3'b000} +: 8] = r[{pos, 3'b000} +: 8] ^ v;
        return r;
    endfunction

    logic [0:0]          state_q, state_d;
    logic [7:0]          byte_ptr_q, byte_ptr_d;
    logic                in_msg_q, in_msg_d;
    logic                pad_pending_q, pad_pending_d;
    logic                tready_q, tready_d;
    logic                blk_last_q, blk_last_d;
    logic                mode_err_q, mode_err_d;
    logic [2:0]          mode_q, mode_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [1599:0]       buf_q, buf_d;

    logic       accept;
    logic       first_beat;
    logic       bad_mode;
    logic [2:0] tuser_m;
    logic [2:0] mode_eff;
    logic [7:0] rate;
    logic [7:0] dom;
    logic [7:0] keep_cnt;
    logic [7:0] end_ptr;

    assign accept     = TVALID & tready_q;
    assign first_beat = ~in_msg_q & (byte_ptr_q == 8'd0);
    assign bad_mode   = TUSER[2] & TUSER[1];
    assign tuser_m    = bad_mode ? 3'd1 : TUSER;
    assign mode_eff   = first_beat ? tuser_m : mode_q;
    assign rate       = rate_of(mode_eff);
    assign dom        = dom_of(mode_eff);
    assign end_ptr    = byte_ptr_q + keep_cnt;

    always_comb begin
        keep_cnt = 8'd0;
        for (int k = 0; k < NB; k++) begin
            keep_cnt = keep_cnt + {7'd0, TKEEP[k]};
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_ptr_d    = byte_ptr_q;
        in_msg_d      = in_msg_q;
        pad_pending_d = pad_pending_q;
        blk_last_d    = blk_last_q;
        mode_d        = mode_q;
        id_d          = id_q;
        buf_d         = buf_q;
        mode_err_d    = 1'b0;

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (first_beat) begin
                        mode_d     = tuser_m;
                        id_d       = TID;
                        mode_err_d = bad_mode;
                    end
                    // TKEEP is contiguous from lane 0, so lane k lands at ptr+k
                    for (int k = 0; k < NB; k++) begin
                        if (TKEEP[k]) begin
                            buf_d = set_byte(buf_d, byte_ptr_q + 8'(k),
                                             TDATA[8*k +: 8]);
                        end
                    end
                    byte_ptr_d = end_ptr;
                    in_msg_d   = ~TLAST;
                    if (TLAST) begin
                        state_d = S_EMIT;
                        if (end_ptr < rate) begin
                            buf_d      = xor_byte(buf_d, end_ptr, dom);
                            buf_d      = xor_byte(buf_d, rate - 8'd1, 8'h80);
                            blk_last_d = 1'b1;
                        end else begin
                            blk_last_d    = 1'b0;
                            pad_pending_d = 1'b1;
                        end
                    end else if (end_ptr == rate) begin
                        state_d    = S_EMIT;
                        blk_last_d = 1'b0;
                    end
                end
            end
            default: begin
                if (blk_ready) begin
                    buf_d = '0;
                    if (pad_pending_q) begin
                        // message ended exactly on a rate boundary: pad-only block
                        buf_d = set_byte(buf_d, 8'd0, dom_of(mode_q));
                        buf_d = xor_byte(buf_d, rate_of(mode_q) - 8'd1, 8'h80);
                        blk_last_d    = 1'b1;
                        pad_pending_d = 1'b0;
                    end else begin
                        byte_ptr_d = 8'd0;
                        state_d    = S_FILL;
                    end
                end
            end
        endcase

        tready_d = (state_d == S_FILL);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q       <= S_FILL;
            byte_ptr_q    <= 8'd0;
            in_msg_q      <= 1'b0;
            pad_pending_q <= 1'b0;
            tready_q      <= 1'b0;
            blk_last_q    <= 1'b0;
            mode_err_q    <= 1'b0;
            mode_q        <= 3'd0;
            id_q          <= '0;
            buf_q         <= '0;
        end else begin
            state_q       <= state_d;
            byte_ptr_q    <= byte_ptr_d;
            in_msg_q      <= in_msg_d;
            pad_pending_q <= pad_pending_d;
            tready_q      <= tready_d;
            blk_last_q    <= blk_last_d;
            mode_err_q    <= mode_err_d;
            mode_q        <= mode_d;
            id_q          <= id_d;
            buf_q         <= buf_d;
        end
    end

    assign TREADY    = tready_q;
    assign blk_valid = (state_q == S_EMIT);
    assign blk_data  = buf_q;
    assign blk_last  = blk_last_q;
    assign blk_mode  = mode_q;
    assign blk_id    = id_q;
    assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_keccak_absorb_packer.sv
// Directed bench for keccak_absorb_packer (DATA_WIDTH=16): padding, block
// boundaries, back-pressure, mode latching and mid-message reset.
module tb_keccak_absorb_packer;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          TVALID = 1'b0;
    logic          TREADY;
    logic [15:0]   TDATA = '0;
    logic [1:0]    TKEEP = '0;
    logic          TLAST = 1'b0;
    logic [2:0]    TUSER = '0;
    logic [7:0]    TID = '0;
    logic          blk_valid;
    logic          blk_ready = 1'b0;
    logic [1599:0] blk_data;
    logic          blk_last;
    logic [2:0]    blk_mode;
    logic [7:0]    blk_id;
    logic          mode_err;

    int vectors = 0;
    int miscompares = 0;

    keccak_absorb_packer #(.DATA_WIDTH(16), .ID_WIDTH(8)) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA), .TKEEP(TKEEP),
        .TLAST(TLAST), .TUSER(TUSER), .TID(TID),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_last(blk_last), .blk_mode(blk_mode), .blk_id(blk_id),
        .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_diff(input logic [1599:0] a,
                                      input logic [1599:0] b);
        for (int i = 0; i < 200; i++)
            if (a[8*i +: 8] !== b[8*i +: 8]) return i;
        return -1;
    endfunction

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input logic [15:0] d, input logic [1:0] k,
                             input logic l, input logic [2:0] u,
                             input logic [7:0] id);
        int n;
        n = 0;
        TVALID = 1'b1; TDATA = d; TKEEP = k; TLAST = l; TUSER = u; TID = id;
        while (!TREADY && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL send_beat timeout: TREADY stayed %b, want 1", TREADY);
        end
        step();
        TVALID = 1'b0; TLAST = 1'b0; TKEEP = '0;
    endtask

    task automatic wait_blk(input string name);
        int n;
        n = 0;
        while (!blk_valid && n < 100) begin
            step();
            n++;
        end
        vectors++;
        if (blk_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s blk_valid timeout got %b want 1", name, blk_valid);
        end
    endtask

    task automatic take_blk();
        blk_ready = 1'b1;
        step();
        blk_ready = 1'b0;
    endtask

    task automatic chk_data(input string name, input logic [1599:0] exp);
        int i;
        vectors++;
        if (blk_data !== exp) begin
            miscompares++;
            i = first_diff(blk_data, exp);
            $display("FAIL %s blk_data byte %0d got %02h want %02h",
                     name, i, blk_data[8*i +: 8], exp[8*i +: 8]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        vectors++;
        if ({TREADY, blk_valid, blk_last, mode_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset flags got %b%b%b%b want 0000",
                     TREADY, blk_valid, blk_last, mode_err);
        end
        vectors++;
        if ({blk_mode, blk_id} !== 11'd0 || blk_data !== '0) begin
            miscompares++;
            $display("FAIL reset regs got mode %0d id %0h want 0 0",
                     blk_mode, blk_id);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (TREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release TREADY got %b want 1", TREADY);
        end
    endtask

    task automatic test_empty_sha3();
        logic [1599:0] exp;
        exp = '0;
        exp[7:0] = 8'h06;
        exp[135*8 +: 8] = 8'h80;
        send_beat(16'h0, 2'b00, 1'b1, 3'd1, 8'h5A);
        vectors++;
        if (blk_valid !== 1'b1 || TREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL empty latency got valid %b ready %b want 1 0",
                     blk_valid, TREADY);
        end
        chk_data("empty", exp);
        vectors++;
        if (blk_last !== 1'b1 || blk_mode !== 3'd1 || blk_id !== 8'h5A) begin
            miscompares++;
            $display("FAIL empty meta got last %b mode %0d id %h want 1 1 5a",
                     blk_last, blk_mode, blk_id);
        end
        take_blk();
        vectors++;
        if (blk_valid !== 1'b0 || TREADY !== 1'b1 || blk_data !== '0) begin
            miscompares++;
            $display("FAIL empty release got valid %b ready %b want 0 1",
                     blk_valid, TREADY);
        end
    endtask

    task automatic test_abc_shake();
        logic [1599:0] exp;
        exp = '0;
        exp[31:0] = 32'h1F63_6261;
        exp[167*8 +: 8] = 8'h80;
        send_beat(16'h6261, 2'b11, 1'b0, 3'd4, 8'h01);
        send_beat(16'h0063, 2'b01, 1'b1, 3'd4, 8'h01);
        wait_blk("abc");
        chk_data("abc", exp);
        vectors++;
        if (blk_last !== 1'b1 || blk_mode !== 3'd4) begin
            miscompares++;
            $display("FAIL abc meta got last %b mode %0d want 1 4",
                     blk_last, blk_mode);
        end
        take_blk();
    endtask

    task automatic test_full_rate();
        logic [1599:0] exp;
        exp = '0;
        for (int i = 0; i < 136; i++) exp[8*i +: 8] = 8'(i);
        for (int j = 0; j < 68; j++)
            send_beat({8'(2*j+1), 8'(2*j)}, 2'b11, j == 67, 3'd1, 8'h02);
        wait_blk("full1");
        chk_data("full1", exp);
        vectors++;
        if (blk_last !== 1'b0) begin
            miscompares++;
            $display("FAIL full1 blk_last got %b want 0", blk_last);
        end
        take_blk();
        exp = '0;
        exp[7:0] = 8'h06;
        exp[135*8 +: 8] = 8'h80;
        vectors++;
        if (blk_valid !== 1'b1 || blk_last !== 1'b1) begin
            miscompares++;
            $display("FAIL full2 got valid %b last %b want 1 1",
                     blk_valid, blk_last);
        end
        chk_data("full2", exp);
        take_blk();
        vectors++;
        if (TREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL full2 release TREADY got %b want 1", TREADY);
        end
    endtask

    task automatic test_135();
        logic [1599:0] exp;
        exp = '0;
        for (int i = 0; i < 135; i++) exp[8*i +: 8] = 8'(i);
        exp[135*8 +: 8] = 8'h86;
        for (int j = 0; j < 67; j++)
            send_beat({8'(2*j+1), 8'(2*j)}, 2'b11, 1'b0, 3'd1, 8'h03);
        send_beat(16'h0086, 2'b01, 1'b1, 3'd1, 8'h03);
        wait_blk("b135");
        chk_data("b135", exp);
        vectors++;
        if (blk_last !== 1'b1) begin
            miscompares++;
            $display("FAIL b135 blk_last got %b want 1", blk_last);
        end
        take_blk();
    endtask

    task automatic test_stall();
        logic [1599:0] exp;
        exp = '0;
        exp[31:0] = 32'h06CC_BBAA;
        exp[71*8 +: 8] = 8'h80;
        send_beat(16'hBBAA, 2'b11, 1'b0, 3'd3, 8'h11);
        send_beat(16'h00CC, 2'b01, 1'b1, 3'd0, 8'h22);
        wait_blk("stall");
        for (int c = 0; c < 5; c++) begin
            chk_data("stall", exp);
            vectors++;
            if (blk_valid !== 1'b1 || TREADY !== 1'b0 || blk_last !== 1'b1) begin
                miscompares++;
                $display("FAIL stall cyc %0d got v %b r %b l %b want 1 0 1",
                         c, blk_valid, TREADY, blk_last);
            end
            step();
        end
        vectors++;
        if (blk_mode !== 3'd3 || blk_id !== 8'h11) begin
            miscompares++;
            $display("FAIL stall latch got mode %0d id %h want 3 11",
                     blk_mode, blk_id);
        end
        take_blk();
    endtask

    task automatic test_reset_mid();
        logic [1599:0] exp;
        exp = '0;
        exp[31:0] = 32'h0603_0201;
        exp[135*8 +: 8] = 8'h80;
        for (int j = 0; j < 4; j++)
            send_beat(16'hEEEE, 2'b11, 1'b0, 3'd2, 8'h44);
        rst_n = 1'b0;
        repeat (2) step();
        vectors++;
        if (blk_valid !== 1'b0 || TREADY !== 1'b0 || blk_data !== '0) begin
            miscompares++;
            $display("FAIL mid_reset got valid %b ready %b want 0 0",
                     blk_valid, TREADY);
        end
        rst_n = 1'b1;
        step();
        send_beat(16'h0201, 2'b11, 1'b0, 3'd7, 8'h77);
        vectors++;
        if (mode_err !== 1'b1) begin
            miscompares++;
            $display("FAIL mode_err pulse got %b want 1", mode_err);
        end
        send_beat(16'h0003, 2'b01, 1'b1, 3'd7, 8'h77);
        vectors++;
        if (mode_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_err width got %b want 0", mode_err);
        end
        wait_blk("post_reset");
        chk_data("post_reset", exp);
        vectors++;
        if (blk_mode !== 3'd1 || blk_last !== 1'b1 || blk_id !== 8'h77) begin
            miscompares++;
            $display("FAIL post_reset meta got mode %0d last %b id %h want 1 1 77",
                     blk_mode, blk_last, blk_id);
        end
        take_blk();
    endtask

    initial begin
        #1;
        test_reset();
        test_empty_sha3();
        test_abc_shake();
        test_full_rate();
        test_135();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
